// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//   Adds two WIDTH-bit operands plus a carry-in one bit per clock, LSB first.
//   A three-state FSM (IDLE -> RUN -> DONE) sequences the operation; the
//   result registers S / c_out only update on the RUN->DONE edge.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   request to begin one addition
//   A, B       in   WIDTH-bit operands, captured when start is accepted
//   C          in   carry-in, captured when start is accepted
//   busy       out  high in every RUN cycle (WIDTH cycles per operation)
//   done       out  one-cycle pulse while in DONE; S / c_out are valid
//   S          out  registered WIDTH-bit sum
//   c_out      out  registered carry-out
//   dbg_state  out  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a request with no ready/ack wire. It is accepted on a
// rising edge where start is high and the FSM is in IDLE or DONE; busy high
// means any start is ignored. An accepted start yields exactly one done
// pulse WIDTH rising edges later, unless rst intervenes.
// ---------------------------------------------------------------------------
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] psum_nxt;

  assign accept    = start && (state != RUN);
  assign last_bit  = (cnt == LAST_BIT);
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 of the
  // result has landed in psum[0].
  assign psum_nxt  = {sum_bit, psum[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN:  if (last_bit) next_state = DONE;
      DONE: next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      c_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B;
      carry <= C;
      psum  <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      psum  <= psum_nxt;
      carry <= carry_nxt;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        S     <= psum_nxt;
        c_out <= carry_nxt;
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one addition.
REQ-005 SHALL have port A  input  WIDTH  first operand, sampled only when start is accepted.
REQ-006 SHALL have port B  input  WIDTH  second operand, sampled only when start is accepted.
REQ-007 SHALL have port C  input  1  carry-in, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port S  output  WIDTH  registered sum result.
REQ-011 SHALL have port c_out  output  1  registered carry-out result.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance it SHALL capture A, B and C into internal shift registers and a carry flop, clear the bit counter, and enter RUN.
REQ-014 SHALL ignore start while in RUN, with no change to operands, counter or outputs.
REQ-015 SHALL process exactly one bit per clock in RUN, LSB first: bit sum = a0 ^ b0 ^ carry; next carry = majority(a0, b0, carry).
REQ-016 SHALL shift both operand registers right by one each RUN cycle and shift each bit sum into a partial-sum register from the MSB side.
REQ-017 SHALL keep the bit counter WIDTH-wide enough to count 0..WIDTH-1 and leave RUN for DONE on the edge that processes bit WIDTH-1.
REQ-018 SHALL, on the RUN->DONE edge, load S with the completed partial sum and c_out with the final carry.
REQ-019 SHALL hold busy high in every RUN cycle, i.e. for exactly WIDTH cycles per operation, and low otherwise.
REQ-020 SHALL assert done for exactly one cycle, in DONE, starting WIDTH rising edges after the edge that accepted start.
REQ-021 SHALL go from DONE to IDLE when start is low, or directly to RUN when start is high (back-to-back, no bubble).
REQ-022 SHALL hold S and c_out stable from the DONE edge until the next RUN->DONE edge; they SHALL NOT change during RUN.
REQ-023 SHALL produce {c_out, S} == A + B + C (mod 2^(WIDTH+1)) for all operand values.
REQ-024 SHALL ignore changes to A, B and C after the accepting edge.

Reset
REQ-025 SHALL, while rst is high and regardless of clk, force state IDLE, busy 0, done 0, S 0, c_out 0, counter 0, carry flop 0 and internal shift registers 0.
REQ-026 SHALL abort any operation in progress when rst asserts mid-RUN, without producing done for it.
REQ-027 SHALL accept start on the first rising edge after rst deasserts.

Verification
REQ-028 SHALL pass, WIDTH=8: A=8'h00, B=8'h00, C=0 -> busy for 8 cycles, done 8 edges after start, S=8'h00, c_out=0.
REQ-029 SHALL pass: A=8'hFF, B=8'h01, C=0 -> S=8'h00, c_out=1 (full carry propagation).
REQ-030 SHALL pass: A=8'hA5, B=8'h5A, C=1 -> S=8'h00, c_out=1; a second start at cycle 3 of RUN with A=8'h3C, B=8'h0F, C=0 is ignored and the result is unchanged.
REQ-031 SHALL pass: start held high in the DONE cycle with A=8'h80, B=8'h80, C=0 -> new RUN with no idle cycle, result S=8'h00, c_out=1.
REQ-032 SHALL pass: rst pulsed in RUN cycle 4 -> busy, done, S and c_out are 0 immediately and no done follows; then A=8'h3C, B=8'h0F, C=0 -> S=8'h4B, c_out=0.
REQ-033 SHALL pass: all 8 combinations of A, B, C with WIDTH=2 restricted to bit 0 (upper bit 0) -> {c_out, S} matches the full-adder truth table in S[0] and S[1].
